// File: rtl/ps2_key_decoder_if.sv
// PS/2 pad lines in, decoded key state out; the decoder takes the slave side.
interface ps2_key_decoder_if;
   logic       ps2_clk;
   logic       ps2_dat;
   logic [3:0] key_value;
   logic [3:0] code_rdy;

   modport master (
      output ps2_clk,
      output ps2_dat,
      input  key_value,
      input  code_rdy
   );

   modport slave (
      input  ps2_clk,
      input  ps2_dat,
      output key_value,
      output code_rdy
   );
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver and game-key decoder; key_value updates 2 clk after the
// filtered stop-bit falling edge. No backpressure: every accepted byte is decoded at once.
module ps2_key_decoder #(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic             clk,
   input  logic             reset,
   ps2_key_decoder_if.slave bus
);

   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1) + 1;

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   logic          clk_s1;
   logic          clk_s2;
   logic          dat_s1;
   logic          dat_s2;
   logic          filt;
   logic          filt_d;
   logic [FW-1:0] filt_cnt;
   logic          fall;

   state_t        state;
   logic [7:0]    shift;
   logic [2:0]    bit_cnt;
   logic          par;
   logic [TW-1:0] tmo_cnt;
   logic          byte_stb;
   logic [7:0]    byte_dat;
   logic          frame_err;

   logic          ext;
   logic          brk;
   logic [3:0]    key;
   logic [3:0]    mapped;
   logic          held;
   logic          press;
   logic          err;
   logic          tog;

   // Synchronizers and filter idle high so a reset never fabricates an edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         clk_s1   <= 1'b1;
         clk_s2   <= 1'b1;
         dat_s1   <= 1'b1;
         dat_s2   <= 1'b1;
         filt     <= 1'b1;
         filt_d   <= 1'b1;
         filt_cnt <= '0;
      end else begin
         clk_s1 <= bus.ps2_clk;
         clk_s2 <= clk_s1;
         dat_s1 <= bus.ps2_dat;
         dat_s2 <= dat_s1;
         filt_d <= filt;
         if (clk_s2 == filt) begin
            filt_cnt <= '0;
         end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
            filt     <= clk_s2;
            filt_cnt <= '0;
         end else begin
            filt_cnt <= filt_cnt + FW'(1);
         end
      end
   end

   assign fall = filt_d & ~filt;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         shift     <= '0;
         bit_cnt   <= '0;
         par       <= 1'b0;
         tmo_cnt   <= '0;
         byte_stb  <= 1'b0;
         byte_dat  <= '0;
         frame_err <= 1'b0;
      end else begin
         byte_stb  <= 1'b0;
         frame_err <= 1'b0;
         if (state == IDLE || fall) begin
            tmo_cnt <= '0;
         end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
         end

         if (state != IDLE && !fall && tmo_cnt >= TW'(TIMEOUT_CYCLES)) begin
            state     <= IDLE;
            shift     <= '0;
            bit_cnt   <= '0;
            frame_err <= 1'b1;
         end else if (fall) begin
            case (state)
               IDLE: begin
                  if (!dat_s2) begin
                     state   <= DATA;
                     bit_cnt <= '0;
                  end
               end
               DATA: begin
                  shift   <= {dat_s2, shift[7:1]};
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     state <= PARITY;
                  end
               end
               PARITY: begin
                  par   <= dat_s2;
                  state <= STOP;
               end
               STOP: begin
                  // Odd parity: data plus parity bit must hold an odd number of ones.
                  if (dat_s2 && (^{shift, par})) begin
                     byte_stb <= 1'b1;
                     byte_dat <= shift;
                  end else begin
                     frame_err <= 1'b1;
                  end
                  state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   always_comb begin
      mapped = 4'd0;
      case ({ext, byte_dat})
         9'h01D:  mapped = 4'd1;
         9'h01C:  mapped = 4'd2;
         9'h01B:  mapped = 4'd3;
         9'h023:  mapped = 4'd4;
         9'h175:  mapped = 4'd5;
         9'h172:  mapped = 4'd6;
         9'h16B:  mapped = 4'd7;
         9'h174:  mapped = 4'd8;
         9'h029:  mapped = 4'd9;
         9'h05A:  mapped = 4'd10;
         9'h076:  mapped = 4'd11;
         9'h04D:  mapped = 4'd12;
         default: mapped = 4'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ext   <= 1'b0;
         brk   <= 1'b0;
         key   <= 4'd0;
         held  <= 1'b0;
         press <= 1'b0;
         err   <= 1'b0;
         tog   <= 1'b0;
      end else begin
         press <= 1'b0;
         if (frame_err) begin
            err <= 1'b1;
            ext <= 1'b0;
            brk <= 1'b0;
         end else if (byte_stb) begin
            if (byte_dat == 8'hE0) begin
               ext <= 1'b1;
            end else if (byte_dat == 8'hF0) begin
               brk <= 1'b1;
            end else begin
               ext <= 1'b0;
               brk <= 1'b0;
               // A break only releases the key that is currently reported.
               if (mapped != 4'd0) begin
                  if (!brk) begin
                     key   <= mapped;
                     held  <= 1'b1;
                     press <= 1'b1;
                     tog   <= ~tog;
                  end else if (mapped == key) begin
                     key  <= 4'd0;
                     held <= 1'b0;
                  end
               end
            end
         end
      end
   end

   assign bus.key_value = key;
   assign bus.code_rdy  = {tog, err, press, held};

endmodule
